// File: rtl/dht11_sched_pkg.sv
// Shared constants and types for the DHT11 read scheduler.
package dht11_sched_pkg;

  localparam logic [1:0] ST_GAP  = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;

  localparam int SRC_HOST = 1;
  localparam int SRC_AUTO = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  src;
  } res_t;

  function automatic int cycles_per_ms(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, synchronously restartable.
module ms_tick_gen #(
  parameter int DIV = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    if (restart_i) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dht11_read_scheduler.sv
// Arbitrates host and periodic reads onto the DHT11 reader with gap, timeout and retry.
module dht11_read_scheduler
  import dht11_sched_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int MIN_GAP_MS = 1000,
  parameter int PERIOD_MS  = 2000,
  parameter int TIMEOUT_MS = 30,
  parameter int MAX_RETRY  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_req_i,
  input  logic        auto_en_i,
  output logic        sens_req_o,
  input  logic        sens_ready_i,
  input  logic [15:0] sens_data_i,
  output logic [15:0] res_data_o,
  output logic        res_valid_o,
  output logic [1:0]  res_src_o,
  output logic        res_err_o,
  output logic        busy_o
);
  localparam int CPM  = cycles_per_ms(CLK_HZ);
  localparam int MAXD = (MIN_GAP_MS > TIMEOUT_MS) ? MIN_GAP_MS : TIMEOUT_MS;
  localparam int DW   = $clog2(MAXD + 1);
  localparam int PW   = $clog2(PERIOD_MS + 1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  if (CPM < 1) begin : g_bad_clk
    $error("dht11_read_scheduler: CLK_HZ gives less than one cycle per ms");
  end

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] ms_q, ms_d;
  logic [PW-1:0] per_q, per_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [1:0]    served_q, served_d;
  logic          rtry_pend_q, rtry_pend_d, launch_q, launch_d;
  logic          host_pend_q, host_pend_d, auto_pend_q, auto_pend_d;
  logic          res_valid_q, res_valid_d, res_err_q, res_err_d, busy_q;
  res_t          res_q, res_d;
  logic          clr_pend, dur_tick, per_tick, dur_restart, per_restart;

  // Duration ticks realign on every state change so gap/timeout lengths are exact.
  assign dur_restart = (state_d != state_q);
  assign per_restart = ~auto_en_i;

  ms_tick_gen #(.DIV(CPM)) u_dur_tick (
    .clk(clk), .rst_n(rst_n), .restart_i(dur_restart), .tick_o(dur_tick));

  ms_tick_gen #(.DIV(CPM)) u_per_tick (
    .clk(clk), .rst_n(rst_n), .restart_i(per_restart), .tick_o(per_tick));

  always_comb begin
    state_d     = state_q;
    ms_d        = ms_q;
    retry_d     = retry_q;
    served_d    = served_q;
    rtry_pend_d = rtry_pend_q;
    launch_d    = 1'b0;
    res_d       = res_q;
    res_valid_d = 1'b0;
    res_err_d   = 1'b0;
    clr_pend    = 1'b0;

    case (state_q)
      ST_GAP: begin
        if (dur_tick) begin
          if (ms_q == DW'(MIN_GAP_MS - 1)) begin
            state_d     = rtry_pend_q ? ST_REQ : ST_IDLE;
            rtry_pend_d = 1'b0;
          end else begin
            ms_d = ms_q + DW'(1);
          end
        end
      end
      ST_IDLE: begin
        // Capture cycle first; the request goes out on the following edge.
        if (launch_q) begin
          state_d = ST_REQ;
        end else if (host_pend_q || auto_pend_q) begin
          served_d[SRC_HOST] = host_pend_q;
          served_d[SRC_AUTO] = auto_pend_q;
          clr_pend           = 1'b1;
          launch_d           = 1'b1;
          retry_d            = RW'(MAX_RETRY);
        end
      end
      ST_REQ: begin
        if (sens_ready_i) begin
          res_d.data  = sens_data_i;
          res_d.src   = served_q;
          res_valid_d = 1'b1;
          state_d     = ST_GAP;
        end else if (dur_tick) begin
          if (ms_q == DW'(TIMEOUT_MS - 1)) begin
            state_d = ST_GAP;
            if (retry_q != '0) begin
              retry_d     = retry_q - RW'(1);
              rtry_pend_d = 1'b1;
            end else begin
              res_err_d = 1'b1;
              res_d.src = served_q;
            end
          end else begin
            ms_d = ms_q + DW'(1);
          end
        end
      end
      default: state_d = ST_GAP;
    endcase

    if (state_d != state_q) ms_d = '0;

    // A request landing on the clearing edge is kept, not lost.
    host_pend_d = (host_pend_q & ~clr_pend) | host_req_i;
    auto_pend_d = auto_pend_q & ~clr_pend;
    per_d       = per_q;
    if (!auto_en_i) begin
      per_d       = '0;
      auto_pend_d = 1'b0;
    end else if (per_tick) begin
      if (per_q == PW'(PERIOD_MS - 1)) begin
        per_d       = '0;
        auto_pend_d = 1'b1;
      end else begin
        per_d = per_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_GAP;
      ms_q        <= '0;
      per_q       <= '0;
      retry_q     <= '0;
      served_q    <= '0;
      rtry_pend_q <= 1'b0;
      launch_q    <= 1'b0;
      host_pend_q <= 1'b0;
      auto_pend_q <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ms_q        <= ms_d;
      per_q       <= per_d;
      retry_q     <= retry_d;
      served_q    <= served_d;
      rtry_pend_q <= rtry_pend_d;
      launch_q    <= launch_d;
      host_pend_q <= host_pend_d;
      auto_pend_q <= auto_pend_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign sens_req_o  = (state_q == ST_REQ);
  assign res_data_o  = res_q.data;
  assign res_src_o   = res_q.src;
  assign res_valid_o = res_valid_q;
  assign res_err_o   = res_err_q;
  assign busy_o      = busy_q;
endmodule
